// File: rtl/dispatch_ctrl.sv
// Dispatch scheduler: buffers one instruction from the IQ and releases it to
// decode once ROB, RS and (for loads/stores) LSQ credits are all available.
//
// state | meaning
// IDLE  | buffer empty, IQ may load it
// HOLD  | buffer valid, waiting for credits or dispatching
// FLUSH | one-cycle recovery after a misprediction flush
module dispatch_ctrl #(
  parameter int ROB_DEPTH = 16,
  parameter int RS_DEPTH  = 16,
  parameter int LSQ_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_flush,
  input  logic        in_iq_valid,
  input  logic [31:0] in_iq_inst,
  input  logic [31:0] in_iq_pc,
  input  logic        in_iq_pred_taken,
  output logic        out_iq_ready,
  output logic        out_dec_ena,
  output logic [31:0] out_dec_inst,
  output logic [31:0] out_dec_pc,
  output logic        out_dec_pred_taken,
  input  logic        in_rob_free,
  input  logic        in_rs_free,
  input  logic        in_lsq_free,
  output logic [31:0] out_stall_cycles,
  output logic        out_credit_err
);

  localparam int ROB_W = $clog2(ROB_DEPTH + 1);
  localparam int RS_W  = $clog2(RS_DEPTH + 1);
  localparam int LSQ_W = $clog2(LSQ_DEPTH + 1);
  localparam logic [ROB_W-1:0] ROB_MAX = ROB_W'(ROB_DEPTH);
  localparam logic [RS_W-1:0]  RS_MAX  = RS_W'(RS_DEPTH);
  localparam logic [LSQ_W-1:0] LSQ_MAX = LSQ_W'(LSQ_DEPTH);

  typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;

  state_t           state;
  logic [31:0]      buf_inst;
  logic [31:0]      buf_pc;
  logic             buf_pred;
  logic [ROB_W-1:0] rob_cnt;
  logic [RS_W-1:0]  rs_cnt;
  logic [LSQ_W-1:0] lsq_cnt;

  logic mem, disp, accept, quiet, lsq_use;
  logic rob_ovf, rs_ovf, lsq_ovf;

  assign mem     = (buf_inst[6:0] == 7'b0000011) || (buf_inst[6:0] == 7'b0100011);
  assign disp    = (state == HOLD) && !in_flush && (rob_cnt != '0) && (rs_cnt != '0)
                   && (!mem || (lsq_cnt != '0));
  assign out_iq_ready = !in_flush && ((state == IDLE) || disp);
  assign accept  = in_iq_valid && out_iq_ready;
  assign out_dec_ena  = disp;
  assign lsq_use = disp && mem;

  // Frees are dropped while credits are being restored by a flush.
  assign quiet   = in_flush || (state == FLUSH);
  assign rob_ovf = in_rob_free && !disp && (rob_cnt == ROB_MAX);
  assign rs_ovf  = in_rs_free && !disp && (rs_cnt == RS_MAX);
  assign lsq_ovf = in_lsq_free && !lsq_use && (lsq_cnt == LSQ_MAX);

  assign out_dec_inst       = buf_inst;
  assign out_dec_pc         = buf_pc;
  assign out_dec_pred_taken = buf_pred;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      buf_inst <= '0;
      buf_pc   <= '0;
      buf_pred <= 1'b0;
    end else begin
      if (accept) begin
        buf_inst <= in_iq_inst;
        buf_pc   <= in_iq_pc;
        buf_pred <= in_iq_pred_taken;
      end
      if (in_flush) begin
        state <= FLUSH;
      end else begin
        unique case (state)
          IDLE:    state <= accept ? HOLD : IDLE;
          HOLD:    state <= (disp && !accept) ? IDLE : HOLD;
          FLUSH:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rob_cnt <= ROB_MAX;
      rs_cnt  <= RS_MAX;
      lsq_cnt <= LSQ_MAX;
    end else if (quiet) begin
      rob_cnt <= ROB_MAX;
      rs_cnt  <= RS_MAX;
      lsq_cnt <= LSQ_MAX;
    end else begin
      if (!rob_ovf) rob_cnt <= rob_cnt - ROB_W'(disp) + ROB_W'(in_rob_free);
      if (!rs_ovf)  rs_cnt  <= rs_cnt - RS_W'(disp) + RS_W'(in_rs_free);
      if (!lsq_ovf) lsq_cnt <= lsq_cnt - LSQ_W'(lsq_use) + LSQ_W'(in_lsq_free);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_stall_cycles <= '0;
      out_credit_err   <= 1'b0;
    end else begin
      if ((state == HOLD) && !disp && !in_flush) out_stall_cycles <= out_stall_cycles + 32'd1;
      if (!quiet && (rob_ovf || rs_ovf || lsq_ovf)) out_credit_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Scoreboard bench for dispatch_ctrl: a driver steps an abstract credit/buffer
// model and queues accepted instructions; a monitor checks each dispatch.
module tb_dispatch_ctrl;

  localparam int DEPTH = 16;
  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] LW   = 32'h0000_2083;
  localparam logic [31:0] SW   = 32'h0010_2023;

  logic        clk, rst_n;
  logic        in_flush, in_iq_valid, in_iq_pred_taken;
  logic [31:0] in_iq_inst, in_iq_pc;
  logic        out_iq_ready, out_dec_ena, out_dec_pred_taken;
  logic [31:0] out_dec_inst, out_dec_pc, out_stall_cycles;
  logic        in_rob_free, in_rs_free, in_lsq_free;
  logic        out_credit_err;

  dispatch_ctrl #(.ROB_DEPTH(DEPTH), .RS_DEPTH(DEPTH), .LSQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_flush(in_flush),
    .in_iq_valid(in_iq_valid), .in_iq_inst(in_iq_inst), .in_iq_pc(in_iq_pc),
    .in_iq_pred_taken(in_iq_pred_taken), .out_iq_ready(out_iq_ready),
    .out_dec_ena(out_dec_ena), .out_dec_inst(out_dec_inst), .out_dec_pc(out_dec_pc),
    .out_dec_pred_taken(out_dec_pred_taken), .in_rob_free(in_rob_free),
    .in_rs_free(in_rs_free), .in_lsq_free(in_lsq_free),
    .out_stall_cycles(out_stall_cycles), .out_credit_err(out_credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_disp   = 0;
  logic [64:0] exp_q[$];

  // abstract model: one buffer slot, integer credits, sticky overflow flag
  bit          m_have, m_recov, m_mem, m_err;
  int          m_rob, m_rs, m_lsq;
  int unsigned m_stall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_mem(input logic [31:0] inst);
    return (inst[6:0] == 7'b0000011) || (inst[6:0] == 7'b0100011);
  endfunction

  function automatic int add_credit(input int cnt, input bit used, input bit freed, inout bit err);
    int r = cnt - int'(used) + int'(freed);
    if (r > DEPTH) begin
      r = DEPTH;
      err = 1'b1;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_have = 0; m_recov = 0; m_mem = 0; m_err = 0;
    m_rob = DEPTH; m_rs = DEPTH; m_lsq = DEPTH; m_stall = 0;
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    in_flush = 0; in_iq_valid = 0; in_iq_inst = '0; in_iq_pc = '0; in_iq_pred_taken = 0;
    in_rob_free = 0; in_rs_free = 0; in_lsq_free = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic step(input bit fl, input bit v, input logic [31:0] inst, input logic [31:0] pc,
                      input bit pr, input bit rf, input bit sf, input bit lf, output bit acc);
    bit e_disp, e_rdy, lsq_used;
    @(negedge clk);
    in_flush = fl; in_iq_valid = v; in_iq_inst = inst; in_iq_pc = pc; in_iq_pred_taken = pr;
    in_rob_free = rf; in_rs_free = sf; in_lsq_free = lf;
    #1;
    e_disp = m_have && !fl && m_rob > 0 && m_rs > 0 && (!m_mem || m_lsq > 0);
    e_rdy  = !fl && !m_recov && (!m_have || e_disp);
    chk("dec_ena", 32'(out_dec_ena), 32'(e_disp));
    chk("iq_ready", 32'(out_iq_ready), 32'(e_rdy));
    chk("stall_cycles", out_stall_cycles, m_stall);
    chk("credit_err", 32'(out_credit_err), 32'(m_err));
    chk("rob_cnt", 32'(dut.rob_cnt), 32'(m_rob));
    chk("rs_cnt", 32'(dut.rs_cnt), 32'(m_rs));
    chk("lsq_cnt", 32'(dut.lsq_cnt), 32'(m_lsq));
    acc = v && e_rdy;
    if (acc) exp_q.push_back({pr, pc, inst});
    if (fl) begin
      exp_q.delete();
      m_have = 0; m_recov = 1;
      m_rob = DEPTH; m_rs = DEPTH; m_lsq = DEPTH;
    end else if (m_recov) begin
      m_recov = 0;
    end else begin
      if (m_have && !e_disp) m_stall++;
      lsq_used = e_disp && m_mem;
      m_rob = add_credit(m_rob, e_disp, rf, m_err);
      m_rs  = add_credit(m_rs, e_disp, sf, m_err);
      m_lsq = add_credit(m_lsq, lsq_used, lf, m_err);
      if (e_disp) m_have = 0;
      if (acc) begin
        m_have = 1;
        m_mem = is_mem(inst);
      end
    end
  endtask

  task automatic idle_step();
    bit a;
    step(0, 0, '0, '0, 0, 0, 0, 0, a);
  endtask

  // monitor: every dispatch strobe must match the oldest accepted instruction
  initial begin
    logic [64:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_dec_ena) begin
        n_disp++;
        if (exp_q.size() == 0) begin
          chk("dispatch_without_accept", 32'(out_dec_ena), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("dec_inst", out_dec_inst, e[31:0]);
          chk("dec_pc", out_dec_pc, e[63:32]);
          chk("dec_pred", 32'(out_dec_pred_taken), 32'(e[64]));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit a;
    int accepted, d0;
    logic [31:0] r, inst;
    logic [6:0] opc;

    rst_n = 0;
    idle_inputs();
    model_reset();
    do_reset();

    // reset values
    #1;
    chk("rst_iq_ready", 32'(out_iq_ready), 32'd1);
    chk("rst_dec_ena", 32'(out_dec_ena), 32'd0);
    chk("rst_stall", out_stall_cycles, 32'd0);
    chk("rst_dec_pc", out_dec_pc, 32'd0);

    // single ALU instruction
    step(0, 1, ADDI, 32'h100, 0, 0, 0, 0, a);
    chk("t1_accept", 32'(a), 32'd1);
    idle_step();
    idle_step();
    chk("t1_disp_count", 32'(n_disp), 32'd1);
    chk("t1_rob", 32'(dut.rob_cnt), 32'd15);
    chk("t1_lsq", 32'(dut.lsq_cnt), 32'd16);

    // 17 back-to-back loads with no frees
    do_reset();
    n_disp = 0;
    accepted = 0;
    for (int i = 0; i < 40 && accepted < 17; i++) begin
      step(0, 1, LW | (32'(accepted) << 20), 32'h200 + 32'(accepted) * 4, accepted[0], 0, 0, 0, a);
      if (a) accepted++;
    end
    chk("t2_accepted", 32'(accepted), 32'd17);
    step(0, 1, LW, 32'h300, 0, 0, 0, 0, a);
    chk("t2_blocked_ready", 32'(a), 32'd0);
    idle_step();
    idle_step();
    chk("t2_disp_16", 32'(n_disp), 32'd16);
    step(0, 0, '0, '0, 0, 0, 0, 1, a);
    idle_step();
    chk("t2_lsq_only", 32'(n_disp), 32'd16);
    step(0, 0, '0, '0, 0, 1, 1, 1, a);
    idle_step();
    idle_step();
    chk("t2_disp_17", 32'(n_disp), 32'd17);

    // RS free arriving in the same cycle as eligibility is not yet usable
    step(0, 1, LW, 32'h400, 1, 0, 0, 0, a);
    step(0, 0, '0, '0, 0, 1, 0, 0, a);
    step(0, 0, '0, '0, 0, 0, 1, 0, a);
    d0 = n_disp;
    idle_step();
    idle_step();
    chk("t3_disp_next", 32'(n_disp), 32'(d0 + 1));
    chk("t3_rs_zero", 32'(dut.rs_cnt), 32'd0);

    // flush while holding with rob_cnt==3
    do_reset();
    accepted = 0;
    for (int i = 0; i < 40 && accepted < 14; i++) begin
      step(0, 1, ADDI, 32'h500 + 32'(accepted) * 4, 0, 0, 0, 0, a);
      if (a) accepted++;
    end
    step(1, 0, '0, '0, 0, 0, 0, 0, a);
    step(0, 1, ADDI, 32'h600, 0, 1, 0, 0, a);
    chk("t4_flush_ready", 32'(a), 32'd0);
    chk("t4_rob_full", 32'(dut.rob_cnt), 32'd16);
    step(0, 1, ADDI, 32'h604, 0, 0, 0, 0, a);
    chk("t4_idle_ready", 32'(a), 32'd1);
    idle_step();

    // free pulse at full credit
    do_reset();
    step(0, 0, '0, '0, 0, 1, 0, 0, a);
    idle_step();
    idle_step();
    chk("t5_err", 32'(out_credit_err), 32'd1);
    chk("t5_rob_hold", 32'(dut.rob_cnt), 32'd16);
    do_reset();
    #1;
    chk("t5_err_cleared", 32'(out_credit_err), 32'd0);

    // async reset mid-cycle while a STORE is buffered
    step(0, 0, '0, '0, 0, 0, 0, 0, a);
    step(0, 1, SW, 32'h700, 1, 0, 0, 0, a);
    @(negedge clk);
    idle_inputs();
    d0 = n_disp;
    rst_n = 0;
    #1;
    chk("t6_dec_ena", 32'(out_dec_ena), 32'd0);
    chk("t6_iq_ready", 32'(out_iq_ready), 32'd1);
    chk("t6_dec_pc", out_dec_pc, 32'd0);
    chk("t6_stall", out_stall_cycles, 32'd0);
    model_reset();
    do_reset();
    chk("t6_no_disp", 32'(n_disp), 32'(d0));

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom();
      case ($urandom_range(0, 3))
        0: opc = 7'b0000011;
        1: opc = 7'b0100011;
        2: opc = 7'b0010011;
        default: opc = r[6:0];
      endcase
      inst = {r[31:7], opc};
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, inst, $urandom(),
           r[7], $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, a);
      if (i == 1500) begin
        do_reset();
      end
    end
    idle_step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
